// File: rtl/pwm.sv
// pwm -- duty-cycle modulator driven by an external step strobe.
//
// An N-bit ramp advances by one on each clock cycle where both ena and step
// are high, so one PWM period is 2^N steps. out is high while the ramp is
// below the active duty value. duty is double-buffered: the shadow copy only
// reloads when the ramp wraps, or on every cycle while the block is disabled.
// Because of this, a period never mixes two duty values.
//
// Ports
//   clk           system clock; all state updates on the rising edge
//   rst           asynchronous active-low reset (0 = reset asserted)
//   ena           enable; when low the ramp is held at 0 and out is forced low
//   step          advance strobe, normally pulse_generator.out
//   duty [N-1:0]  requested high time in steps (0 .. 2^N-1)
//   out           PWM output
//   period_start  one-cycle strobe, high in the cycle of the wrapping advance
module pwm #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         step,
  input  logic [N-1:0] duty,
  output logic         out,
  output logic         period_start
);

  localparam logic [N-1:0] CNT_MAX = '1;

  logic [N-1:0] counter_q, counter_d;
  logic [N-1:0] duty_active_q, duty_active_d;
  logic         adv;
  logic         at_top;

  assign adv    = ena & step;
  assign at_top = (counter_q == CNT_MAX);

  always_comb begin
    counter_d     = counter_q;
    duty_active_d = duty_active_q;
    if (!ena) begin
      // While disabled, keep the shadow tracking the request. The first
      // period after enable then starts with the current duty.
      counter_d     = '0;
      duty_active_d = duty;
    end else if (adv) begin
      // The wrap from 2^N-1 to 0 comes from natural N-bit overflow.
      counter_d = counter_q + 1'b1;
      if (at_top) begin
        duty_active_d = duty;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter_q     <= '0;
      duty_active_q <= '0;
    end else begin
      counter_q     <= counter_d;
      duty_active_q <= duty_active_d;
    end
  end

  // Both outputs are combinational. Forcing the state to zero therefore
  // drops them at once when reset asserts or when ena falls.
  assign out          = ena & (counter_q < duty_active_q);
  assign period_start = adv & at_top;

endmodule

// File: doc/pwm.md
# pwm

Duty-cycle modulator that sits directly downstream of `pulse_generator`. It consumes that block's one-cycle `out` strobe as its `step` input and advances an N-bit ramp once per strobe. It drives a PWM output whose high time is `duty` steps out of every 2^N steps. `duty` is double-buffered so that changes only take effect on period boundaries, and a period-boundary strobe is provided for software or chained blocks.

## Interface
- `N`, 8, ramp/duty width; PWM period = 2^N steps
- `clk`  input  1  system clock, all state updates on rising edge
- `rst`  input  1  asynchronous, active-low reset (0 = reset asserted)
- `ena`  input  1  enable; when low, ramp held at 0 and output forced low
- `step`  input  1  advance strobe, normally `pulse_generator.out`; one step per clk cycle it is high
- `duty`  input  N  requested high time in steps (0 .. 2^N-1)
- `out`  output  1  PWM output
- `period_start`  output  1  one-cycle strobe marking the step that wraps the ramp to 0

## Operation
- State: `counter` [N-1:0] (ramp), `duty_active` [N-1:0] (shadow of `duty`).
- Advance condition: `adv = ena & step`.
- counter next state:
  - if `!ena`: 0
  - else if `adv`: counter + 1, wrapping 2^N-1 -> 0 by natural N-bit overflow
  - else: hold
- duty_active next state:
  - if `!ena`: load `duty` every cycle (so the first period after enable uses the current request)
  - else if `adv` and counter == 2^N-1: load `duty`
  - else: hold
- `out = ena & (counter < duty_active)`, combinational from registers and `ena`, unsigned N-bit compare.
- `period_start = adv & (counter == 2^N-1)`, combinational; it is high in the same cycle as the wrapping edge.
- Duty range:
  - duty 0: out never high.
  - duty 2^N-1: out low for exactly 1 step per period.
  - 100% is not representable; this is intentional.
- `step` high while `ena` is low is ignored.
- `step` high on consecutive cycles advances on every one of those cycles.

## Timing
- Reset (`rst`=0, async): counter=0, duty_active=0. Therefore out=0 and period_start=0 immediately, without waiting for a clock edge.
- Reset release: state updates on the first rising clk edge with `rst`=1.
- Latency `step` -> `out` change: one clk edge. `out` reflects the new counter in the cycle after the advancing edge.
- Duty latency: a `duty` value present on the wrapping edge is captured. It governs `out` starting in the cycle after that edge, i.e. when counter=0. Changes of `duty` mid-period have no effect on the current period.
- `ena` falling: `out` goes low in the same cycle (combinational). counter clears to 0 on the next edge, discarding the partial period. No `period_start` is generated.
- `ena` rising: counter is already 0 and duty_active holds the latest `duty`. The first step begins period 1 with no glitch.
- Simultaneous wrap and `duty` change: the new `duty` is captured (last-value-wins at the edge).
- Reset mid-period: all state is cleared asynchronously. The next period starts from counter=0 with duty_active=0 until the next wrap or `!ena` reload.

## Test plan
- N=4, ena=1, step=1 every cycle, duty=4 held from reset: first period out=0 (duty_active=0 after reset); from the cycle after the first period_start, out high 4 cycles then low 12, repeating. period_start pulses every 16 cycles.
- N=4, step from `pulse_generator` with ticks=2 (one strobe per 3 clk), duty=8: out high 24 clk cycles, low 24, period 48 clk. period_start is 1 clk wide.
- N=4, duty=0 then duty=15: duty=0 -> out never high over 3 periods; duty=15 -> out high 15 steps, low exactly 1 step (counter=15) per period.
- N=4, duty=4 running; change duty to 10 when counter=7: the current period still ends high time at step 4. The next period is high for 10 steps.
- N=4, ena=1 ramp at counter=9: drop ena for 5 cycles with step active -> out=0 immediately, counter=0, no period_start. Set duty=6 while ena=0, re-enable -> the first period is high 6 steps.
- N=4, assert rst=0 asynchronously between clk edges at counter=11, duty_active=12: out and period_start fall before the next edge, counter=0 and duty_active=0. After release, out stays low until the first wrap loads duty.
